// File: rtl/stdp_pkg.sv
// Shared types and sizing for the STDP neuron slice: widths, membrane/weight types and the LIF state enum.
package stdp_pkg;

    localparam int NUM_PRE = 5;
    localparam int W_WIDTH = 5;
    localparam int V_WIDTH = 8;
    // Wide enough that NUM_PRE full-scale weights can never overflow.
    localparam int SUM_W   = W_WIDTH + $clog2(NUM_PRE);

    typedef enum logic [1:0] {
        INTEGRATE,
        FIRE,
        REFRACT
    } lif_state_t;

    typedef logic [W_WIDTH-1:0] weight_t;
    typedef logic [V_WIDTH-1:0] membrane_t;
    typedef logic [SUM_W-1:0]   sum_t;

    // Clamp a one-bit-wider membrane update to the largest representable value.
    function automatic membrane_t sat_membrane(input logic [V_WIDTH:0] acc);
        return acc[V_WIDTH] ? '1 : acc[V_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/lif_post_neuron_if.sv
// Spike/weight-load bus of the LIF postsynaptic neuron; the neuron is the slave.
interface lif_post_neuron_if;
    import stdp_pkg::*;

    logic [NUM_PRE-1:0] pre_spike;
    logic               w_load;
    logic [2:0]         w_idx;
    weight_t            w_data;
    logic               post_spike;
    membrane_t          membrane_out;
    logic               refractory;

    modport master (
        output pre_spike, w_load, w_idx, w_data,
        input  post_spike, membrane_out, refractory
    );

    modport slave (
        input  pre_spike, w_load, w_idx, w_data,
        output post_spike, membrane_out, refractory
    );

endinterface

// File: rtl/weighted_spike_sum.sv
// Combinational masked adder: sums the weights of every input whose spike bit is set.
module weighted_spike_sum
    import stdp_pkg::*;
(
    input  weight_t            weights [NUM_PRE],
    input  logic [NUM_PRE-1:0] spikes,
    output sum_t               sum
);

    sum_t masked [NUM_PRE];

    generate
        for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_mask
            assign masked[gi] = spikes[gi] ? sum_t'(weights[gi]) : '0;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            sum = sum + masked[i];
        end
    end

endmodule

// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron with loadable synaptic weights and a refractory period.
// Define LIF_LEAK_EN to subtract the v >> LEAK_SHIFT leak term; otherwise it is a pure integrate-and-fire.
module lif_post_neuron
    import stdp_pkg::*;
#(
    parameter int THRESHOLD     = 32,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRAC_CYCLES = 4,
    parameter int INIT_WEIGHT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    lif_post_neuron_if.slave bus
);

    localparam int        CNT_W    = $clog2(REFRAC_CYCLES + 2);
    localparam int        ACC_W    = V_WIDTH + 1;
    localparam membrane_t THRESH_V = membrane_t'(THRESHOLD);
`ifdef LIF_LEAK_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    weight_t          weights_reg [NUM_PRE];
    sum_t             sum_comb;
    sum_t             syn_sum_reg;
    lif_state_t       state_reg;
    membrane_t        v_reg;
    membrane_t        leak;
    membrane_t        v_next;
    logic [ACC_W-1:0] acc;
    logic             post_reg;
    logic             refr_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Out-of-range indices match no entry, so they write nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PRE; i++) begin
            if (rst) begin
                weights_reg[i] <= weight_t'(INIT_WEIGHT);
            end else if (bus.w_load && bus.w_idx == 3'(i)) begin
                weights_reg[i] <= bus.w_data;
            end
        end
    end

    weighted_spike_sum u_sum (
        .weights (weights_reg),
        .spikes  (bus.pre_spike),
        .sum     (sum_comb)
    );

    always_comb begin
        leak   = LEAK_EN ? (v_reg >> LEAK_SHIFT) : '0;
        acc    = {1'b0, v_reg} - {1'b0, leak} + ACC_W'(syn_sum_reg);
        v_next = sat_membrane(acc);
    end

    // Stage 1 registers the weighted sum; stage 2 is the integrate/fire/refract FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            syn_sum_reg <= '0;
            state_reg   <= INTEGRATE;
            v_reg       <= '0;
            post_reg    <= 1'b0;
            refr_reg    <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            syn_sum_reg <= sum_comb;
            post_reg    <= 1'b0;
            case (state_reg)
                INTEGRATE: begin
                    if (v_next >= THRESH_V) begin
                        v_reg     <= '0;
                        post_reg  <= 1'b1;
                        refr_reg  <= 1'b1;
                        state_reg <= FIRE;
                    end else begin
                        v_reg <= v_next;
                    end
                end
                FIRE: begin
                    v_reg <= '0;
                    if (REFRAC_CYCLES == 0) begin
                        refr_reg  <= 1'b0;
                        state_reg <= INTEGRATE;
                    end else begin
                        refr_reg  <= 1'b1;
                        cnt_reg   <= CNT_W'(REFRAC_CYCLES);
                        state_reg <= REFRACT;
                    end
                end
                REFRACT: begin
                    v_reg <= '0;
                    if (cnt_reg == CNT_W'(1)) begin
                        refr_reg  <= 1'b0;
                        state_reg <= INTEGRATE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= INTEGRATE;
            endcase
        end
    end

    assign bus.post_spike   = post_reg;
    assign bus.membrane_out = v_reg;
    assign bus.refractory   = refr_reg;

endmodule

// File: doc/lif_post_neuron.md
Name: lif_post_neuron

Overview:
- Leaky integrate-and-fire postsynaptic neuron that generates the `post_spike` consumed by the STDP learning block.
- Holds one synaptic weight per presynaptic input and sums the weights of the inputs that spike each cycle.
- Integrates that sum into a leaky membrane potential, fires on threshold crossing, then enters a refractory period.
- Weights are written through a simple load port, so the learning block or host can update them.

Parameters:
- NUM_PRE, 5, number of presynaptic inputs
- W_WIDTH, 5, synaptic weight width (unsigned)
- V_WIDTH, 8, membrane potential width (unsigned)
- THRESHOLD, 32, firing threshold; fire when membrane >= THRESHOLD
- LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT per update
- REFRAC_CYCLES, 4, refractory length in cycles (0 allowed)
- INIT_WEIGHT, 8, reset value of every weight

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pre_spike  in  NUM_PRE  presynaptic spike vector, one bit per input
- w_load  in  1  weight write strobe
- w_idx  in  3  weight index to write
- w_data  in  W_WIDTH  weight value to write
- post_spike  out  1  postsynaptic spike, one-cycle pulse
- membrane_out  out  V_WIDTH  current membrane potential
- refractory  out  1  high during FIRE and REFRACT states

Behaviour:
- Reset, when `rst`=1 at an edge:
  - all weights = INIT_WEIGHT; syn_sum = 0; membrane = 0
  - post_spike = 0; refractory = 0; state = INTEGRATE; refractory counter = 0
- Stage 1 (registered):
  - syn_sum = sum of weights[i] over all i where pre_spike[i]=1
  - width SUM_W = W_WIDTH + clog2(NUM_PRE), so no overflow
  - Uses weights as held before the edge. A same-edge `w_load` takes effect next cycle.
- Weight write: `w_load`=1 writes `w_data` to weights[w_idx]. `w_idx` >= NUM_PRE is ignored, with no side effect.
- Stage 2, FSM with states INTEGRATE, FIRE, REFRACT:
  - INTEGRATE:
    - v_next = v - (v >> LEAK_SHIFT) + syn_sum, computed at V_WIDTH+1 bits
    - saturate to 2^V_WIDTH - 1
    - if v_next >= THRESHOLD: membrane = 0, post_spike = 1, go to FIRE
    - else: membrane = v_next
  - FIRE (exactly one cycle):
    - post_spike returns to 0 at next edge; syn_sum discarded; membrane held at 0
    - go to REFRACT with counter = REFRAC_CYCLES; if REFRAC_CYCLES=0, go to INTEGRATE
  - REFRACT:
    - syn_sum discarded; membrane held at 0; counter decrements each cycle
    - at counter == 1, go to INTEGRATE
    - the first integration uses syn_sum from the following cycle
- Latency: pre_spike sampled at edge N → syn_sum at edge N → membrane/post_spike at edge N+1, i.e. post_spike visible 2 cycles after pre_spike is presented.
- post_spike is registered and is never high two consecutive cycles.
- refractory is registered and high in FIRE and REFRACT.
- Reset mid-FIRE or mid-REFRACT aborts to the reset state immediately, with no pending spike.

Optional Feature:
- Macro LIF_LEAK_EN.
- Defined: leak term v >> LEAK_SHIFT is subtracted as above.
- Undefined: pure integrate-and-fire, v_next = v + syn_sum, saturated; LEAK_SHIFT is unused.

Decomposition:
- Shared package `stdp_pkg`:
  - NUM_PRE, W_WIDTH, V_WIDTH, SUM_W constants
  - `lif_state_t` enum {INTEGRATE, FIRE, REFRACT}
  - typedefs `weight_t`, `membrane_t`
- Sub-module `weighted_spike_sum`: combinational masked adder over NUM_PRE weights producing SUM_W bits. The stage-1 register lives in the parent.

Test Plan:
- Reset, then pre_spike=5'b11111 for one cycle → syn_sum=40; post_spike=1 two cycles later; membrane_out=0; refractory high for 5 cycles (FIRE + 4); no second spike.
- pre_spike=5'b00001 held every cycle, LIF_LEAK_EN defined → membrane 8, 15, 22, 28, then fire on 5th update (33 >= 32). Undefined → 8, 16, 24, then fire on 4th (32).
- THRESHOLD=255 instance, all weights loaded 31, pre_spike=5'b11111 held → membrane 155, then saturates (291 → 255) and fires; no wrap to small value.
- Spike, then pre_spike=5'b11111 held through REFRACT → membrane_out stays 0 for all 5 refractory cycles; integration resumes with 40 on the next update.
- w_load idx=2 data=0 on the same edge as pre_spike=5'b00100 → sum uses old weight 8. Repeat pre_spike next cycle → sum contribution 0. w_load idx=7 → no weight changes.
- Assert rst during REFRACT (counter=2) → next cycle post_spike=0, refractory=0, membrane_out=0, weights=INIT_WEIGHT.
